// File: rtl/pp_pipeline_accel_fifo_param_pkg.sv
// Shared helpers for the pp_pipeline parametrised stream FIFO: width math and
// the legal parameter bounds that the top checks at elaboration.
package pp_fifo_pkg;

    localparam int MIN_DEPTH      = 2;
    localparam int MIN_DATA_WIDTH = 1;
    localparam int MIN_OUT_REG    = 0;
    localparam int MAX_OUT_REG    = 1;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest   = rest >> 1;
        end
        return result;
    endfunction

    // Occupancy counter width: must hold 0..DEPTH+1.
    function automatic int cnt_width(input int depth);
        return clog2(depth + 2);
    endfunction

endpackage

// File: rtl/pp_pipeline_accel_fifo_param_if.sv
// HLS-style read/write channel of the parametrised FIFO; master is the
// producer/consumer side, slave is the FIFO itself.
interface pp_pipeline_accel_fifo_param_if
    import pp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = cnt_width(2)
);
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_write;
    logic                  if_write_ce;
    logic                  if_full_n;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_read;
    logic                  if_read_ce;
    logic                  if_empty_n;
    logic [CNT_WIDTH-1:0]  if_num_data_valid;
    logic [CNT_WIDTH-1:0]  if_fifo_cap;
    logic                  if_almost_full;
    logic                  if_almost_empty;
    logic                  if_overflow;
    logic                  if_underflow;

    modport master (
        output if_din, if_write, if_write_ce, if_read, if_read_ce,
        input  if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap,
               if_almost_full, if_almost_empty, if_overflow, if_underflow
    );

    modport slave (
        input  if_din, if_write, if_write_ce, if_read, if_read_ce,
        output if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap,
               if_almost_full, if_almost_empty, if_overflow, if_underflow
    );
endinterface

// File: rtl/pp_pipeline_accel_fifo_param_srl.sv
// DEPTH-entry shift-register storage: entry 0 takes the new word on ce, read
// is an asynchronous mux by address. Contents are never reset.
module pp_pipeline_accel_fifo_param_srl
    import pp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = cnt_width(2)
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] q
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      hit;

    always_ff @(posedge clk) begin
        if (ce) begin
            mem[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        assign hit[gi] = (addr == ADDR_WIDTH'(gi));
    end

    // Out-of-range addresses (empty FIFO) select nothing and read as zero.
    always_comb begin
        q = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i]) begin
                q = mem[i];
            end
        end
    end

endmodule

// File: rtl/pp_pipeline_accel_fifo_param.sv
// Parametrised inter-stage stream FIFO: shift-register storage, optional
// output register, registered full/empty/count, threshold and sticky error flags.
module pp_pipeline_accel_fifo_param
    import pp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int OUT_REG    = 0,
    parameter int AF_THRESH  = DEPTH,
    parameter int AE_THRESH  = 0,
    parameter int CNT_WIDTH  = cnt_width(DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    pp_pipeline_accel_fifo_param_if.slave  bus
);
    localparam int CAP = DEPTH + ((OUT_REG != 0) ? 1 : 0);

    if (DEPTH < MIN_DEPTH) begin : g_bad_depth
        $error("pp_pipeline_accel_fifo_param: DEPTH must be at least %0d", MIN_DEPTH);
    end
    if (DATA_WIDTH < MIN_DATA_WIDTH) begin : g_bad_width
        $error("pp_pipeline_accel_fifo_param: DATA_WIDTH must be at least %0d", MIN_DATA_WIDTH);
    end
    if (OUT_REG < MIN_OUT_REG || OUT_REG > MAX_OUT_REG) begin : g_bad_out_reg
        $error("pp_pipeline_accel_fifo_param: OUT_REG must be 0 or 1");
    end

    logic [CNT_WIDTH-1:0]  sc_reg, sc_next;
    logic [CNT_WIDTH-1:0]  count_reg, count_next;
    logic                  ov_reg, ov_next;
    logic                  full_n_reg, full_n_next;
    logic                  empty_n_reg, empty_n_next;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;
    logic                  wr, rd, load, dec;
    logic                  wr_reject, rd_reject;
    logic [CNT_WIDTH-1:0]  rd_addr;
    logic [DATA_WIDTH-1:0] srl_q;

    // Requests seen while reset is asserted never reach the storage.
    assign wr        = reset_n & bus.if_write & bus.if_write_ce & full_n_reg;
    assign rd        = reset_n & bus.if_read & bus.if_read_ce & empty_n_reg;
    assign wr_reject = bus.if_write & bus.if_write_ce & ~full_n_reg;
    assign rd_reject = bus.if_read & bus.if_read_ce & ~empty_n_reg;
    assign rd_addr   = sc_reg - CNT_WIDTH'(1);

    pp_pipeline_accel_fifo_param_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (CNT_WIDTH)
    ) u_srl (
        .clk  (clk),
        .ce   (wr),
        .d    (bus.if_din),
        .addr (rd_addr),
        .q    (srl_q)
    );

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] head_reg;

        // Refill the head whenever it is empty or being consumed; the storage
        // read uses the pre-shift address, so a same-cycle write is harmless.
        assign load = (sc_reg != '0) & (~ov_reg | rd);
        assign dec  = load;

        always_ff @(posedge clk) begin
            if (load) begin
                head_reg <= srl_q;
            end
        end

        assign bus.if_dout = head_reg;
    end else begin : g_out_comb
        assign load        = 1'b0;
        assign dec         = rd;
        assign bus.if_dout = srl_q;
    end

    always_comb begin
        sc_next        = sc_reg + CNT_WIDTH'(wr) - CNT_WIDTH'(dec);
        ov_next        = (OUT_REG != 0) ? (load | (ov_reg & ~rd)) : 1'b0;
        count_next     = sc_next + CNT_WIDTH'(ov_next);
        full_n_next    = (count_next < CNT_WIDTH'(CAP));
        empty_n_next   = (OUT_REG != 0) ? ov_next : (sc_next != '0);
        overflow_next  = overflow_reg | wr_reject;
        underflow_next = underflow_reg | rd_reject;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sc_reg        <= '0;
            count_reg     <= '0;
            ov_reg        <= 1'b0;
            full_n_reg    <= 1'b1;
            empty_n_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            sc_reg        <= sc_next;
            count_reg     <= count_next;
            ov_reg        <= ov_next;
            full_n_reg    <= full_n_next;
            empty_n_reg   <= empty_n_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign bus.if_full_n         = full_n_reg;
    assign bus.if_empty_n        = empty_n_reg;
    assign bus.if_num_data_valid = count_reg;
    assign bus.if_fifo_cap       = CNT_WIDTH'(CAP);
    assign bus.if_almost_full    = (count_reg >= CNT_WIDTH'(AF_THRESH));
    assign bus.if_almost_empty   = (count_reg <= CNT_WIDTH'(AE_THRESH));
    assign bus.if_overflow       = overflow_reg;
    assign bus.if_underflow      = underflow_reg;

endmodule
